ethernet_tx_framer: RTL and testbench
=====================================

// Module: ethernet_tx_framer
// PURPOSE
// - Transmit-side counterpart of the Ethernet II type decoder. Takes one L2 frame from the TX arbiter (dst MAC, ethertype, payload), buffers its payload, then emits header + payload + pad on a 32-bit MAC TX stream.
// - Sits between the TX arbiter and the per-link elastic buffers; single clock domain (clk_ipstack). FCS/preamble remain the MAC's job.
// PARAMETERS
// - PAYLOAD_DEPTH  512  payload FIFO depth in 32-bit words (power of 2); frames longer are dropped
// - MIN_FRAME      60   minimum emitted bytes (header+payload+pad, excl. FCS); 64 when ETH_TX_VLAN_EN defined
// PORTS
// - clk               in   1   clock (clk_ipstack)
// - rst_n             in   1   asynchronous active-low reset
// - our_mac_address   in   48  source MAC; sampled at in_start
// - in_ready          out  1   high when framer is IDLE and can accept in_start
// - in_start          in   1   frame start strobe; latches in_dst_mac, in_ethertype
// - in_dst_mac        in   48  destination MAC
// - in_ethertype      in   16  ethertype
// - in_data_valid     in   1   payload word strobe
// - in_bytes_valid    in   3   valid bytes in in_data (1..4, MSB-first)
// - in_data           in   32  payload, in_data[31:24] is first byte
// - in_commit         in   1   end of frame, queue for transmit
// - in_drop           in   1   abort current frame
// - tx_ready          in   1   downstream accepts a word this cycle
// - tx_start          out  1   high with first header word
// - tx_data_valid     out  1   word present on tx_data
// - tx_bytes_valid    out  3   valid bytes in tx_data (4 except last word)
// - tx_data           out  32  frame word, big-endian byte order
// - tx_commit         out  1   one-cycle strobe after last word accepted
// - tx_overflow       out  1   one-cycle strobe when a frame is discarded for size
// BEHAVIOUR
// - Reset: all outputs 0 except in_ready=1 one cycle after rst_n rises; FIFO empty; state IDLE. Reset mid-frame discards it, no tx_commit.
// - States: IDLE -> COLLECT (in_start) -> HDR (in_commit) -> BODY -> PAD (if len<MIN_FRAME) -> DONE -> IDLE.
// - in_start outside IDLE ignored. in_data_valid/in_commit/in_drop outside COLLECT ignored.
// - COLLECT: each in_data_valid pushes word; byte count += in_bytes_valid (16-bit, saturates never: overflow rule first).
// - in_bytes_valid<4 is legal only on last word; a later data word in same frame is ignored.
// - Push into full FIFO: flush FIFO, pulse tx_overflow, return IDLE. in_drop: flush, IDLE, no output.
// - in_commit with same-cycle in_data_valid: word is pushed, then commit. Zero-length payload legal (padded).
// - HDR starts the cycle after in_commit (first tx word 1 cycle after commit). Words: dst[47:16]; {dst[15:0],src[47:32]}; src[31:0]; {ethertype, payload byte0, byte1}.
// - BODY: 16-bit realignment register; each word = 2 held bytes + 2 new FIFO bytes; final partial word sets tx_bytes_valid=1..4 unless padding follows.
// - PAD: zero bytes until total = MIN_FRAME; last pad word bytes_valid = remainder (4 when aligned).
// - Handshake: word advances only when tx_data_valid && tx_ready; tx_data/tx_bytes_valid/tx_start held stable while tx_ready=0. No bubbles required when FIFO non-empty.
// - tx_commit: one cycle after the last word is accepted; in_ready returns the following cycle.
// - Sustained throughput: one word/cycle with tx_ready=1; one frame in flight at a time.
// CONFIGURATION
// - ETH_TX_VLAN_EN defined: extra port vlan_tci in 16 (sampled at in_start); 802.1Q tag {16'h8100, vlan_tci} inserted after src MAC, so ethertype word shifts by 4 bytes; MIN_FRAME=64.
// - Undefined: no vlan_tci port, no tag, MIN_FRAME=60; header is exactly 14 bytes.
// TESTING
// - dst=02:11:22:33:44:55, ethertype 0x0800, 8-byte payload 01..08, tx_ready=1 -> words 0x02112233,0x445502FF,0xDEADBEEF,0x08000102, 0x03040506,0x07080000, then zero pad to 60 bytes, last bytes_valid=4, tx_commit once.
// - 46-byte payload (no pad needed) with tx_ready toggled 1/0 every cycle -> 60 bytes out unchanged, data stable during stalls, no pad words.
// - 47-byte payload -> 61 bytes, final word tx_bytes_valid=1, tx_commit 1 cycle after its acceptance.
// - PAYLOAD_DEPTH+1 words pushed -> tx_overflow pulse, no tx_data_valid, in_ready=1 next frame accepted normally.
// - in_drop after 3 words, then new frame -> only second frame emitted; in_start during HDR ignored; rst_n low mid-BODY -> outputs 0, no tx_commit.
// - ETH_TX_VLAN_EN, vlan_tci=0x0005, zero payload -> tag 0x81000005 after src MAC, ethertype next, total 64 bytes.

Source files
------------

// File: rtl/ethernet_tx_framer.sv
// ethernet_tx_framer: buffers one L2 payload, then streams dst MAC, src MAC,
// an optional 802.1Q tag, the ethertype, the payload and zero pad onto a
// 32-bit big-endian TX stream. The payload starts two bytes into a word, so
// the body realigns through a 16-bit holding register.
// Optional feature: define ETH_TX_VLAN_EN to add the vlan_tci port and the tag.
module ethernet_tx_framer #(
   parameter int PAYLOAD_DEPTH = 512,
`ifdef ETH_TX_VLAN_EN
   parameter int MIN_FRAME     = 64
`else
   parameter int MIN_FRAME     = 60
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [47:0] our_mac_address,
   output logic        in_ready,
   input  logic        in_start,
   input  logic [47:0] in_dst_mac,
   input  logic [15:0] in_ethertype,
   input  logic        in_data_valid,
   input  logic [2:0]  in_bytes_valid,
   input  logic [31:0] in_data,
   input  logic        in_commit,
   input  logic        in_drop,
   input  logic        tx_ready,
   output logic        tx_start,
   output logic        tx_data_valid,
   output logic [2:0]  tx_bytes_valid,
   output logic [31:0] tx_data,
   output logic        tx_commit,
   output logic        tx_overflow
`ifdef ETH_TX_VLAN_EN
   ,
   input  logic [15:0] vlan_tci
`endif
);

   localparam int AW = $clog2(PAYLOAD_DEPTH);
`ifdef ETH_TX_VLAN_EN
   localparam logic [15:0] HW_L = 16'd5;   // words holding header bytes
   localparam logic [15:0] HB_L = 16'd18;  // header bytes
`else
   localparam logic [15:0] HW_L = 16'd4;
   localparam logic [15:0] HB_L = 16'd14;
`endif
   localparam logic [15:0] MIN_L = 16'(MIN_FRAME);

   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_HDR, S_BODY, S_PAD, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [AW:0]     wr_cnt_q, wr_cnt_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [15:0]     len_q, len_d;
   logic [15:0]     wcnt_q, wcnt_d;
   logic            short_q, short_d;
   logic            ovf_q, ovf_d;
   logic            rdy_q, rdy_d;

   logic [47:0]     dst_q, src_q;
   logic [15:0]     et_q;
`ifdef ETH_TX_VLAN_EN
   logic [15:0]     tci_q;
`endif
   logic [15:0]     hold_q;
   logic [31:0]     mem_q [PAYLOAD_DEPTH];

   logic            hdr_ld, mem_we, hold_ld;
   logic            emit, push_req, full;
   logic [2:0]      bv_eff;
   logic [31:0]     head, raw, word;
   logic [15:0]     end_pos, tot, last_w, next_pos;
   logic [2:0]      last_bv;

   // Output word formation: header/realigned payload, zeroed past the payload end
   always_comb begin
      logic [15:0] pos;
      emit     = (state_q == S_HDR) || (state_q == S_BODY) || (state_q == S_PAD);
      end_pos  = HB_L + len_q;
      tot      = (end_pos < MIN_L) ? MIN_L : end_pos;
      last_w   = ((tot + 16'd3) >> 2) - 16'd1;
      last_bv  = 3'(tot - (last_w << 2));
      next_pos = (wcnt_q + 16'd1) << 2;
      head     = mem_q[rd_ptr_q];
      raw      = 32'd0;
      if (wcnt_q < HW_L - 16'd1) begin
         case (wcnt_q[2:0])
            3'd0:    raw = dst_q[47:16];
            3'd1:    raw = {dst_q[15:0], src_q[47:32]};
            3'd2:    raw = src_q[31:0];
`ifdef ETH_TX_VLAN_EN
            default: raw = {16'h8100, tci_q};
`else
            default: raw = src_q[31:0];
`endif
         endcase
      end else if (wcnt_q == HW_L - 16'd1) begin
         raw = {et_q, head[31:16]};
      end else begin
         raw = {hold_q, head[31:16]};
      end
      word = raw;
      for (int i = 0; i < 4; i++) begin
         pos = {wcnt_q[13:0], 2'b00} + 16'(i);
         if (pos >= end_pos) word[31-8*i -: 8] = 8'd0;
      end
   end

   // Next-state and control: collect payload, then walk the output words
   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_ptr_d = rd_ptr_q;
      len_d    = len_q;
      wcnt_d   = wcnt_q;
      short_d  = short_q;
      ovf_d    = 1'b0;
      rdy_d    = 1'b1;
      hdr_ld   = 1'b0;
      mem_we   = 1'b0;
      hold_ld  = 1'b0;
      bv_eff   = (in_bytes_valid > 3'd4) ? 3'd4 : in_bytes_valid;
      push_req = in_data_valid && !short_q && (in_bytes_valid != 3'd0);
      full     = (wr_cnt_q == (AW+1)'(PAYLOAD_DEPTH));

      case (state_q)
         S_IDLE: begin
            if (in_start && rdy_q) begin
               state_d  = S_COLLECT;
               hdr_ld   = 1'b1;
               wr_cnt_d = '0;
               len_d    = '0;
               short_d  = 1'b0;
            end
         end
         S_COLLECT: begin
            if (in_drop) begin
               state_d  = S_IDLE;
               wr_cnt_d = '0;
            end else if (push_req && full) begin
               state_d  = S_IDLE;
               wr_cnt_d = '0;
               ovf_d    = 1'b1;
            end else begin
               if (push_req) begin
                  mem_we   = 1'b1;
                  wr_cnt_d = wr_cnt_q + (AW+1)'(1);
                  len_d    = len_q + 16'(bv_eff);
                  if (bv_eff != 3'd4) short_d = 1'b1;
               end
               if (in_commit) begin
                  state_d  = S_HDR;
                  wcnt_d   = '0;
                  rd_ptr_d = '0;
               end
            end
         end
         S_HDR, S_BODY, S_PAD: begin
            if (tx_ready) begin
               wcnt_d = wcnt_q + 16'd1;
               // From the ethertype word on, each accepted word consumes one FIFO word
               if (wcnt_q >= HW_L - 16'd1) begin
                  rd_ptr_d = rd_ptr_q + AW'(1);
                  hold_ld  = 1'b1;
               end
               if (wcnt_q == last_w)
                  state_d = S_DONE;
               else if (next_pos >= end_pos)
                  state_d = S_PAD;
               else if (wcnt_q == HW_L - 16'd1)
                  state_d = S_BODY;
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            wr_cnt_d = '0;
         end
         default: state_d = S_IDLE;
      endcase

      in_ready       = rdy_q && (state_q == S_IDLE);
      tx_data_valid  = emit;
      tx_start       = emit && (wcnt_q == 16'd0);
      tx_data        = emit ? word : 32'd0;
      tx_bytes_valid = emit ? ((wcnt_q == last_w) ? last_bv : 3'd4) : 3'd0;
      tx_commit      = (state_q == S_DONE);
      tx_overflow    = ovf_q;
   end

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_cnt_q <= '0;
         rd_ptr_q <= '0;
         len_q    <= '0;
         wcnt_q   <= '0;
         short_q  <= 1'b0;
         ovf_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_ptr_q <= rd_ptr_d;
         len_q    <= len_d;
         wcnt_q   <= wcnt_d;
         short_q  <= short_d;
         ovf_q    <= ovf_d;
         rdy_q    <= rdy_d;
      end
   end

   // Data registers: header fields, payload FIFO storage, realignment hold
   always_ff @(posedge clk) begin
      if (hdr_ld) begin
         dst_q <= in_dst_mac;
         src_q <= our_mac_address;
         et_q  <= in_ethertype;
`ifdef ETH_TX_VLAN_EN
         tci_q <= vlan_tci;
`endif
      end
      if (mem_we) mem_q[wr_cnt_q[AW-1:0]] <= in_data;
      if (hold_ld) hold_q <= head[15:0];
   end

endmodule

// File: tb/tb_ethernet_tx_framer.sv
// Bench for ethernet_tx_framer: directed tables plus randomized frames checked
// against a byte-list reference (header bytes, payload, zero pad to minimum).
module tb_ethernet_tx_framer;
   localparam int DEPTH = 512;
`ifdef ETH_TX_VLAN_EN
   localparam int MINF = 64;
`else
   localparam int MINF = 60;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [47:0] our_mac_address, in_dst_mac;
   logic        in_ready, in_start;
   logic [15:0] in_ethertype;
   logic        in_data_valid;
   logic [2:0]  in_bytes_valid;
   logic [31:0] in_data;
   logic        in_commit, in_drop, tx_ready;
   logic        tx_start, tx_data_valid;
   logic [2:0]  tx_bytes_valid;
   logic [31:0] tx_data;
   logic        tx_commit, tx_overflow;
`ifdef ETH_TX_VLAN_EN
   logic [15:0] vlan_tci;
`endif

   ethernet_tx_framer #(.PAYLOAD_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .our_mac_address(our_mac_address),
      .in_ready(in_ready), .in_start(in_start), .in_dst_mac(in_dst_mac),
      .in_ethertype(in_ethertype), .in_data_valid(in_data_valid),
      .in_bytes_valid(in_bytes_valid), .in_data(in_data), .in_commit(in_commit),
      .in_drop(in_drop), .tx_ready(tx_ready), .tx_start(tx_start),
      .tx_data_valid(tx_data_valid), .tx_bytes_valid(tx_bytes_valid),
      .tx_data(tx_data), .tx_commit(tx_commit), .tx_overflow(tx_overflow)
`ifdef ETH_TX_VLAN_EN
      , .vlan_tci(vlan_tci)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [7:0]  pl[$];
   logic [7:0]  exp_b[$];
   logic [7:0]  rx_b[$];
   logic [31:0] rx_w[$];
   logic [2:0]  rx_bv[$];
   logic [15:0] cur_tci = 16'h0000;

   typedef struct {int len; int mode; int total; int last_bv;} case_t;
   typedef struct {logic [31:0] w; logic [2:0] bv;} wexp_t;
   case_t cases[8];
   wexp_t dir[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [47:0] rnd48();
      return {16'($urandom()), 32'($urandom())};
   endfunction

   // Reference frame: header bytes in wire order, payload, zeros up to minimum
   task automatic build_exp(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et);
      exp_b.delete();
      for (int i = 0; i < 6; i++) exp_b.push_back(dst[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) exp_b.push_back(src[47-8*i -: 8]);
`ifdef ETH_TX_VLAN_EN
      exp_b.push_back(8'h81); exp_b.push_back(8'h00);
      exp_b.push_back(cur_tci[15:8]); exp_b.push_back(cur_tci[7:0]);
`endif
      exp_b.push_back(et[15:8]); exp_b.push_back(et[7:0]);
      foreach (pl[i]) exp_b.push_back(pl[i]);
      while (exp_b.size() < MINF) exp_b.push_back(8'h00);
   endtask

   task automatic fill_pl(input int len);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom()));
   endtask

   task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                             input int gap_pct, input bit commit_sep, input bit extra);
      int t, nw, nb, len;
      logic [31:0] w32;
      len = pl.size();
      t = 0;
      while (!in_ready && t < 200) begin step(); t++; end
      chk("in_ready_before_start", 64'(in_ready), 64'd1);
      in_start = 1'b1; in_dst_mac = dst; our_mac_address = src; in_ethertype = et;
`ifdef ETH_TX_VLAN_EN
      vlan_tci = cur_tci;
`endif
      step();
      in_start = 1'b0; in_dst_mac = rnd48(); our_mac_address = rnd48();
      in_ethertype = 16'($urandom());
`ifdef ETH_TX_VLAN_EN
      vlan_tci = 16'($urandom());
`endif
      nw = (len + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            in_data_valid = 1'b0; in_data = $urandom();
            in_bytes_valid = 3'($urandom_range(1, 4));
            step();
         end
         w32 = $urandom();
         nb = (len - 4*w >= 4) ? 4 : len - 4*w;
         for (int b = 0; b < nb; b++) w32[31-8*b -: 8] = pl[4*w+b];
         in_data_valid = 1'b1; in_data = w32; in_bytes_valid = 3'(nb);
         in_commit = (w == nw-1) && !commit_sep;
         step();
      end
      in_data_valid = 1'b0;
      if (nw == 0 || commit_sep) begin
         if (extra && (len % 4) != 0) begin
            in_data_valid = 1'b1; in_data = $urandom(); in_bytes_valid = 3'd4;
            step();
            in_data_valid = 1'b0;
         end
         in_commit = 1'b1;
         step();
      end
      in_commit = 1'b0;
   endtask

   task automatic rx_frame(input int mode, input bit poke, input int exp_total,
                           input int exp_last, input string tag);
      int commits, stable_bad, start_bad, bubble_bad, timing_bad, bv_bad, mism, cyc, n;
      bit acc_prev, stall_prev, done, r;
      logic [31:0] pd, tw;
      logic [2:0]  pbv;
      commits = 0; stable_bad = 0; start_bad = 0; bubble_bad = 0; timing_bad = 0;
      bv_bad = 0; mism = 0; cyc = 0; acc_prev = 0; stall_prev = 0; done = 0;
      pd = '0; pbv = '0;
      rx_w.delete(); rx_bv.delete(); rx_b.delete();
      chk({tag, "_first_word_latency"}, {62'd0, tx_data_valid, tx_start}, 64'd3);
      while (!done && cyc < 4000) begin
         case (mode)
            0:       r = 1'b1;
            1:       r = (cyc % 2 == 0);
            default: r = 1'($urandom_range(1));
         endcase
         tx_ready = r;
         if (poke && cyc == 1) begin in_start = 1'b1; in_dst_mac = ~in_dst_mac; end
         if (poke && cyc == 2) in_start = 1'b0;
         if (tx_commit) begin
            commits++;
            if (!acc_prev) timing_bad++;
            done = 1'b1;
         end else if (!tx_data_valid) begin
            bubble_bad++;
         end
         if (tx_data_valid) begin
            if (stall_prev && (tx_data !== pd || tx_bytes_valid !== pbv)) stable_bad++;
            if (tx_start !== (rx_w.size() == 0)) start_bad++;
            if (r) begin rx_w.push_back(tx_data); rx_bv.push_back(tx_bytes_valid); end
         end
         acc_prev = tx_data_valid && r;
         stall_prev = tx_data_valid && !r;
         pd = tx_data; pbv = tx_bytes_valid;
         step();
         cyc++;
      end
      tx_ready = 1'b0; in_start = 1'b0;
      chk({tag, "_commit_count"}, 64'(commits), 64'd1);
      chk({tag, "_commit_timing"}, 64'(timing_bad), 64'd0);
      chk({tag, "_ready_after_commit"}, {62'd0, in_ready, tx_commit}, 64'd2);
      chk({tag, "_stall_stable"}, 64'(stable_bad), 64'd0);
      chk({tag, "_tx_start"}, 64'(start_bad), 64'd0);
      chk({tag, "_no_bubbles"}, 64'(bubble_bad), 64'd0);
      n = rx_w.size();
      for (int i = 0; i < n; i++) begin
         tw = rx_w[i];
         if (i != n-1 && rx_bv[i] != 3'd4) bv_bad++;
         for (int b = 0; b < 4 && b < int'(rx_bv[i]); b++) rx_b.push_back(tw[31-8*b -: 8]);
      end
      chk({tag, "_inner_bytes_valid"}, 64'(bv_bad), 64'd0);
      chk({tag, "_byte_count"}, 64'(rx_b.size()), 64'(exp_b.size()));
      for (int i = 0; i < rx_b.size() && i < exp_b.size(); i++)
         if (rx_b[i] !== exp_b[i]) mism++;
      chk({tag, "_bytes"}, 64'(mism), 64'd0);
      if (exp_total >= 0) chk({tag, "_total_table"}, 64'(rx_b.size()), 64'(exp_total));
      if (exp_last >= 0 && n > 0) chk({tag, "_last_bv_table"}, 64'(rx_bv[n-1]), 64'(exp_last));
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] d, s;
      logic [15:0] e;
      int cnt_v, cnt_o, cnt_c, len;
      our_mac_address = '0; in_start = 0; in_dst_mac = '0; in_ethertype = '0;
      in_data_valid = 0; in_bytes_valid = '0; in_data = '0; in_commit = 0;
      in_drop = 0; tx_ready = 0;
`ifdef ETH_TX_VLAN_EN
      vlan_tci = '0;
      cases[0] = '{0, 0, 64, 4};  cases[1] = '{8, 2, 64, 4};
      cases[2] = '{46, 1, 64, 4}; cases[3] = '{47, 0, 65, 1};
      cases[4] = '{48, 2, 66, 2}; cases[5] = '{49, 1, 67, 3};
      cases[6] = '{50, 0, 68, 4}; cases[7] = '{101, 2, 119, 3};
      dir.push_back('{32'h02112233, 3'd4}); dir.push_back('{32'h445502FF, 3'd4});
      dir.push_back('{32'hDEADBEEF, 3'd4}); dir.push_back('{32'h81000005, 3'd4});
      dir.push_back('{32'h08000000, 3'd4});
      while (dir.size() < 16) dir.push_back('{32'h0, 3'd4});
`else
      cases[0] = '{0, 0, 60, 4};  cases[1] = '{8, 2, 60, 4};
      cases[2] = '{46, 1, 60, 4}; cases[3] = '{47, 0, 61, 1};
      cases[4] = '{48, 2, 62, 2}; cases[5] = '{49, 1, 63, 3};
      cases[6] = '{50, 0, 64, 4}; cases[7] = '{101, 2, 115, 3};
      dir.push_back('{32'h02112233, 3'd4}); dir.push_back('{32'h445502FF, 3'd4});
      dir.push_back('{32'hDEADBEEF, 3'd4}); dir.push_back('{32'h08000102, 3'd4});
      dir.push_back('{32'h03040506, 3'd4}); dir.push_back('{32'h07080000, 3'd4});
      while (dir.size() < 15) dir.push_back('{32'h0, 3'd4});
`endif

      repeat (3) step();
      chk("reset_outputs", {tx_data_valid, tx_start, tx_commit, tx_overflow, tx_bytes_valid, tx_data}, 64'd0);
      rst_n = 1'b1;
      step();
      chk("in_ready_after_reset", 64'(in_ready), 64'd1);

      // Reference frame with known words
      pl.delete();
`ifdef ETH_TX_VLAN_EN
      cur_tci = 16'h0005;
`else
      for (int i = 1; i <= 8; i++) pl.push_back(8'(i));
`endif
      send_frame(48'h021122334455, 48'h02FFDEADBEEF, 16'h0800, 0, 0, 0);
      build_exp(48'h021122334455, 48'h02FFDEADBEEF, 16'h0800);
      rx_frame(0, 0, MINF, 4, "known");
      chk("known_word_count", 64'(rx_w.size()), 64'(dir.size()));
      for (int i = 0; i < dir.size(); i++) begin
         chk($sformatf("known_word%0d", i), (i < rx_w.size()) ? 64'(rx_w[i]) : 64'hBAD, 64'(dir[i].w));
         chk($sformatf("known_bv%0d", i), (i < rx_bv.size()) ? 64'(rx_bv[i]) : 64'hBAD, 64'(dir[i].bv));
      end

      // Length table: pad boundary, odd tails, stall patterns; one poke of in_start
      foreach (cases[k]) begin
         fill_pl(cases[k].len);
         cur_tci = 16'($urandom());
         d = rnd48(); s = rnd48(); e = 16'($urandom());
         send_frame(d, s, e, 20, 1'($urandom_range(1)), 1'($urandom_range(1)));
         build_exp(d, s, e);
         rx_frame(cases[k].mode, (k == 2), cases[k].total, cases[k].last_bv, $sformatf("len%0d", cases[k].len));
      end

      // Drop after 3 words: nothing emitted, then a normal frame
      in_start = 1'b1; in_dst_mac = rnd48(); step(); in_start = 1'b0;
      for (int w = 0; w < 3; w++) begin
         in_data_valid = 1'b1; in_bytes_valid = 3'd4; in_data = $urandom(); step();
      end
      in_data_valid = 1'b0; in_drop = 1'b1; step(); in_drop = 1'b0;
      tx_ready = 1'b1; cnt_v = 0; cnt_c = 0;
      for (int c = 0; c < 5; c++) begin
         if (tx_data_valid) cnt_v++;
         if (tx_commit) cnt_c++;
         step();
      end
      tx_ready = 1'b0;
      chk("drop_no_output", 64'(cnt_v + cnt_c), 64'd0);
      chk("drop_in_ready", 64'(in_ready), 64'd1);
      fill_pl(20); d = rnd48(); s = rnd48(); e = 16'h86DD;
      send_frame(d, s, e, 0, 0, 0); build_exp(d, s, e);
      rx_frame(0, 0, -1, -1, "after_drop");

      // Overflow: one word more than the FIFO holds
      in_start = 1'b1; in_dst_mac = rnd48(); step(); in_start = 1'b0;
      cnt_v = 0; cnt_o = 0; tx_ready = 1'b1;
      for (int w = 0; w <= DEPTH; w++) begin
         in_data_valid = 1'b1; in_bytes_valid = 3'd4; in_data = $urandom();
         step();
         if (tx_overflow) cnt_o++;
         if (tx_data_valid) cnt_v++;
      end
      in_data_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (tx_overflow) cnt_o++;
         if (tx_data_valid) cnt_v++;
      end
      tx_ready = 1'b0;
      chk("overflow_pulses", 64'(cnt_o), 64'd1);
      chk("overflow_no_tx", 64'(cnt_v), 64'd0);
      chk("overflow_in_ready", 64'(in_ready), 64'd1);
      fill_pl(33); d = rnd48(); s = rnd48(); e = 16'h0806;
      send_frame(d, s, e, 10, 1, 0); build_exp(d, s, e);
      rx_frame(2, 0, -1, -1, "after_overflow");

      // Reset in the middle of the body
      fill_pl(40); d = rnd48(); s = rnd48(); e = 16'h0800;
      send_frame(d, s, e, 0, 0, 0);
      tx_ready = 1'b1;
      repeat (6) step();
      chk("midbody_was_sending", 64'(tx_data_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midbody_reset_outputs", {tx_data_valid, tx_start, tx_commit, tx_overflow, tx_bytes_valid, tx_data}, 64'd0);
      cnt_c = 0;
      repeat (2) begin step(); if (tx_commit || tx_data_valid) cnt_c++; end
      rst_n = 1'b1;
      step();
      if (tx_commit || tx_data_valid) cnt_c++;
      tx_ready = 1'b0;
      chk("midbody_no_commit", 64'(cnt_c), 64'd0);
      chk("midbody_in_ready", 64'(in_ready), 64'd1);

      // Randomized frames against the reference
      for (int f = 0; f < 12; f++) begin
         len = int'($urandom_range(0, 130));
         fill_pl(len);
         cur_tci = 16'($urandom());
         d = rnd48(); s = rnd48(); e = 16'($urandom());
         send_frame(d, s, e, int'($urandom_range(0, 40)), 1'($urandom_range(1)), 1'($urandom_range(1)));
         build_exp(d, s, e);
         rx_frame(int'($urandom_range(0, 2)), 1'($urandom_range(1)), -1, -1, $sformatf("rand%0d", f));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
